// File: rtl/lock_pkg.sv
// Shared definitions for the serial lock and its code serializer.
package lock_pkg;

    localparam int unsigned LOCK_WIDTH      = 3;
    localparam int unsigned LOCK_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } ser_state_t;

endpackage

// File: rtl/lock_code_serializer.sv
// Parallel-to-serial feeder for the digital lock: MSB-first shift, guard gap of ones,
// and a one-word holding register so the next word can be accepted while shifting.
module lock_code_serializer
    import lock_pkg::*;
#(
    parameter int unsigned WIDTH      = LOCK_WIDTH,
    parameter int unsigned GAP_CYCLES = LOCK_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             code,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_MAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    ser_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic             r_code;
    logic             r_busy;
    logic             r_done;
    logic             r_din_ready;

    ser_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic             w_hold_full_nxt;
    logic             w_code_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_ready_nxt;
    logic             w_xfer;

    assign w_xfer    = din_valid && r_din_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sr_nxt        = r_sr;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_SHIFT;
                    w_sr_nxt    = din;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (w_xfer) begin
                    w_hold_nxt      = din;
                    w_hold_full_nxt = 1'b1;
                end
                if (r_cnt == SHIFT_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = (GAP_LAST == '0);
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_sr_nxt  = {r_sr[WIDTH-2:0], 1'b0};
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    // Held word takes priority; ready is low whenever hold is full.
                    w_cnt_nxt = '0;
                    if (r_hold_full) begin
                        w_state_nxt     = ST_SHIFT;
                        w_sr_nxt        = r_hold;
                        w_hold_full_nxt = 1'b0;
                    end else if (w_xfer) begin
                        w_state_nxt = ST_SHIFT;
                        w_sr_nxt    = din;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_hold_nxt      = din;
                        w_hold_full_nxt = 1'b1;
                    end
                    w_cnt_nxt  = w_cnt_inc;
                    w_done_nxt = (w_cnt_inc == GAP_LAST);
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cnt_nxt       = '0;
                w_hold_full_nxt = 1'b0;
            end
        endcase

        w_code_nxt  = (w_state_nxt == ST_SHIFT) ? w_sr_nxt[WIDTH-1] : 1'b1;
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_ready_nxt = !w_hold_full_nxt;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_sr        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_code      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_din_ready <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_sr        <= w_sr_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_code      <= w_code_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_din_ready <= w_ready_nxt;
        end
    end

    assign din_ready = r_din_ready;
    assign code      = r_code;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_lock_code_serializer.sv
// Self-checking bench for lock_code_serializer against a word-schedule reference model.
module tb_lock_code_serializer;
    import lock_pkg::*;

    localparam int unsigned W = LOCK_WIDTH;
    localparam int unsigned G = LOCK_GAP_CYCLES;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         din_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_ready;
    logic         code;
    logic         busy;
    logic         done;

    lock_code_serializer #(.WIDTH(W), .GAP_CYCLES(G)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .code      (code),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Each accepted word owns the window start .. start+W+G-1; it is held from acc+1 to start-1.
    typedef struct {
        int           acc;
        int           start;
        logic [W-1:0] data;
    } word_t;

    typedef struct packed {
        logic code;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    word_t q[$];
    int    free_slot = 0;
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic exp_t expect_now();
        exp_t e;
        int   k;
        e = '{code: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1};
        foreach (q[i]) begin
            k = cyc - q[i].start;
            if (cyc > q[i].acc && cyc < q[i].start) e.ready = 1'b0;
            if (k >= 0 && k < int'(W + G)) begin
                e.busy = 1'b1;
                if (k < int'(W)) e.code = q[i].data[int'(W) - 1 - k];
                else             e.done = (k == int'(W + G) - 1);
            end
        end
        return e;
    endfunction

    // Drive one cycle of inputs, update the model, and move to the next cycle.
    task automatic advance(input logic v, input logic [W-1:0] d, input logic r);
        exp_t e;
        int   st;
        reset     = r;
        din_valid = v;
        din       = d;
        e = expect_now();
        if (!r && v && e.ready) begin
            st = (cyc + 1 > free_slot) ? cyc + 1 : free_slot;
            q.push_back('{acc: cyc, start: st, data: d});
            free_slot = st + int'(W + G);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            q.delete();
            free_slot = 0;
        end
        while (q.size() > 0 && q[0].start + int'(W + G) <= cyc) void'(q.pop_front());
    endtask

    task automatic test_reset();
        exp_t e;
        advance(1'b0, '0, 1'b1);
        advance(1'b1, 3'b111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            e = expect_now();
            n_cmp++;
            if ({code, busy, done, din_ready} !== e || e !== 4'b1001) begin
                n_err++;
                $display("FAIL reset cyc=%0d code/busy/done/rdy got=%b exp=%b", cyc, {code, busy, done, din_ready}, e);
            end
            advance(1'b0, W'($urandom), 1'b0);
        end
    endtask

    task automatic test_single();
        exp_t       e;
        logic [4:0] seq;
        seq = 5'b01011;
        advance(1'b1, 3'b010, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            e = expect_now();
            n_cmp++;
            if ({code, busy, done, din_ready} !== e) begin
                n_err++;
                $display("FAIL single cyc=%0d code/busy/done/rdy got=%b exp=%b", cyc, {code, busy, done, din_ready}, e);
            end
            if (k <= 5) begin
                n_cmp++;
                if (code !== seq[5-k] || done !== (k == 5)) begin
                    n_err++;
                    $display("FAIL single_seq t+%0d code/done got=%b%b exp=%b%b", k, code, done, seq[5-k], k == 5);
                end
            end
            advance(1'b0, W'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 14; k++) begin
            if (k == 0)      advance(1'b1, 3'b010, 1'b0);
            else if (k == 1) advance(1'b1, 3'b110, 1'b0);
            else             advance(1'b0, W'($urandom), 1'b0);
            e = expect_now();
            n_cmp++;
            if ({code, busy, done, din_ready} !== e) begin
                n_err++;
                $display("FAIL back_to_back cyc=%0d code/busy/done/rdy got=%b exp=%b", cyc, {code, busy, done, din_ready}, e);
            end
        end
    endtask

    task automatic test_last_gap();
        exp_t e;
        for (int k = 0; k < 14; k++) begin
            if (k == 0)                  advance(1'b1, 3'b101, 1'b0);
            else if (k == int'(W + G))   advance(1'b1, 3'b011, 1'b0);
            else                         advance(1'b0, W'($urandom), 1'b0);
            e = expect_now();
            n_cmp++;
            if ({code, busy, done, din_ready} !== e) begin
                n_err++;
                $display("FAIL last_gap cyc=%0d code/busy/done/rdy got=%b exp=%b", cyc, {code, busy, done, din_ready}, e);
            end
        end
    endtask

    task automatic test_reset_hold();
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            if (k == 0)      advance(1'b1, 3'b110, 1'b0);
            else if (k == 1) advance(1'b1, 3'b001, 1'b0);
            else if (k == 2) advance(1'b1, 3'b111, 1'b1);
            else             advance(1'b0, W'($urandom), 1'b0);
            e = expect_now();
            n_cmp++;
            if ({code, busy, done, din_ready} !== e || (k == 2 && e !== 4'b1001)) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d code/busy/done/rdy got=%b exp=%b", cyc, {code, busy, done, din_ready}, e);
            end
        end
    endtask

    task automatic test_stream();
        exp_t e;
        for (int k = 0; k < 410; k++) begin
            if (k < 400) advance(($urandom_range(0, 9) != 0), W'($urandom), 1'b0);
            else         advance(1'b0, W'($urandom), 1'b0);
            e = expect_now();
            n_cmp++;
            if ({code, busy, done, din_ready} !== e) begin
                n_err++;
                $display("FAIL stream cyc=%0d code/busy/done/rdy got=%b exp=%b", cyc, {code, busy, done, din_ready}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_last_gap();
        test_reset_hold();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lock_code_serializer.md
# lock_code_serializer

Upstream feeder for the serial digital lock. Accepts a parallel code word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on the single-bit `code` line that drives the lock's `code` input. After each word it drives a guard gap of ones, which returns the downstream lock FSM to its idle state. A one-word holding register lets the next word be accepted while the current one shifts.

## Interface
- `WIDTH`, default 3: code word length in bits; legal range ≥ 2.
- `GAP_CYCLES`, default 2: number of idle-high cycles after each word; legal range 1..15. A value of 2 is sufficient to return the lock to its idle state from any state.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  parallel code word; bit WIDTH-1 is sent first.
- `din_valid`  in  1  `din` is presented for transfer.
- `din_ready`  out  1  registered; the block can accept a word this cycle.
- `code`  out  1  registered serial output to the lock; idles at 1.
- `busy`  out  1  registered; high during shift or gap cycles.
- `done`  out  1  registered; one-cycle pulse on the final gap cycle of each word.

## Operation
- States: IDLE, SHIFT, GAP.
- Resources:
  - Shift register `sr[WIDTH-1:0]`.
  - Bit counter sized for max(WIDTH, GAP_CYCLES).
  - Holding register `hold` with flag `hold_full`.
- Transfer occurs on any cycle with `din_valid && din_ready`. `din` is ignored otherwise and while `reset` is high.
- IDLE:
  - `code`=1, `busy`=0.
  - On transfer: load `sr`=`din`, go to SHIFT.
- SHIFT:
  - `code`=`sr[WIDTH-1]`, and `sr` shifts left each cycle.
  - After WIDTH cycles, go to GAP.
  - A transfer while here loads `hold` and sets `hold_full`.
- GAP:
  - `code`=1 for GAP_CYCLES cycles.
  - On the last gap cycle, `done`=1.
  - Next state after the last gap cycle:
    - If `hold_full`: load `sr`=`hold`, clear `hold_full`, go to SHIFT.
    - Else, if a transfer occurs in this same cycle: load `sr`=`din`, go to SHIFT.
    - Otherwise go to IDLE.
- `din_ready` is 1 whenever `hold_full` is 0 in the next-state view, including IDLE. It is 0 while `hold_full`=1.
- A transfer is never dropped. A second word is never accepted while `hold` is occupied.
- There is no word-level back-pressure from the lock. The lock always consumes one bit per clock.

## Timing
- Reset values (the cycle after `reset` is sampled high):
  - `code`=1, `busy`=0, `done`=0, `din_ready`=1.
  - State IDLE, `hold_full`=0, counter=0.
- Latency: for a transfer at cycle t:
  - First data bit appears on `code` at t+1; last data bit at t+WIDTH.
  - Gap occupies t+WIDTH+1 .. t+WIDTH+GAP_CYCLES.
  - `done` is high at t+WIDTH+GAP_CYCLES.
  - `busy` is high from t+1 through t+WIDTH+GAP_CYCLES inclusive.
- Back-to-back words: the next word's first bit directly follows the last gap cycle, with no idle bubble. Throughput is one word per WIDTH+GAP_CYCLES cycles.
- Reset mid-operation aborts the current word and clears `hold`. Reset dominates a simultaneous transfer.
- If `din_valid` is high while `din_ready`=0, state is unchanged and the producer must hold `din` stable.

## Structure
- Shared package `lock_pkg`:
  - State encoding: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, with the fourth code recovering to IDLE.
  - Default WIDTH/GAP constants shared with the lock.
- Single module; no sub-module needed. The bit counter is inline.

## Test plan
- Reset, then idle for 5 cycles → `code`=1, `busy`=0, `done`=0, `din_ready`=1 throughout.
- WIDTH=3, GAP=2: transfer 3'b010 at t → `code` = 0,1,0,1,1 at t+1..t+5; `done` only at t+5. With the lock attached, `openlock`=1 in the cycle after the last data bit is sampled.
- Transfer 3'b010 then 3'b110 on consecutive cycles → second is held and `din_ready`=0 from t+2 until the handoff. `code` = 0,1,0,1,1,1,1,0,1,1 with no bubble.
- Transfer in the last GAP cycle with `hold` empty → next word's MSB at the following cycle.
- Assert `reset` at t+2 of a word with `hold_full`=1 → `code`=1, `busy`=0, `din_ready`=1 next cycle, and the held word is discarded.
- Hold `din_valid`=1 continuously with changing `din` while stalled → only words present on `din_ready`=1 cycles are serialized, each exactly once.
